// File: rtl/dsp_fetch_unit.sv
// Instruction fetch / PC sequencer: one outstanding imem request, valid/ready hand-off to decode.
// Optional perf counters (flush_count, fetch_count) when DSP_FETCH_PERF_CNT_EN is defined.
module dsp_fetch_unit #(
  parameter int                  ADDR_LEN   = 16,
  parameter int                  INSTR_LEN  = 32,
  parameter logic [ADDR_LEN-1:0] RESET_ADDR = {ADDR_LEN{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 jump_flag,
  input  logic [ADDR_LEN-1:0]  jump_addr,
  output logic                 imem_req,
  output logic [ADDR_LEN-1:0]  imem_addr,
  input  logic                 imem_ack,
  input  logic [INSTR_LEN-1:0] imem_rdata,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [INSTR_LEN-1:0] instr_out,
  output logic [ADDR_LEN-1:0]  instr_pc
`ifdef DSP_FETCH_PERF_CNT_EN
  ,
  output logic [15:0]          flush_count,
  output logic [15:0]          fetch_count
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  localparam logic [ADDR_LEN-1:0] PC_STEP = {{(ADDR_LEN-1){1'b0}}, 1'b1};

  logic [1:0]          state_reg;
  logic [ADDR_LEN-1:0] pc_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pc_reg      <= RESET_ADDR;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_ADDR;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
    end else if (jump_flag) begin
      // A redirect squashes whatever is held and steers the next request.
      pc_reg      <= jump_addr;
      instr_valid <= 1'b0;
      case (state_reg)
        REQ: begin
          if (imem_ack) begin
            imem_addr <= jump_addr;
          end else begin
            state_reg <= DISCARD;
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            imem_addr <= jump_addr;
            state_reg <= REQ;
          end
        end
        default: begin
          imem_req  <= 1'b1;
          imem_addr <= jump_addr;
          state_reg <= REQ;
        end
      endcase
    end else begin
      case (state_reg)
        IDLE: begin
          imem_req  <= 1'b1;
          imem_addr <= pc_reg;
          state_reg <= REQ;
        end
        REQ: begin
          if (imem_ack) begin
            instr_out   <= imem_rdata;
            instr_pc    <= pc_reg;
            instr_valid <= 1'b1;
            pc_reg      <= pc_reg + PC_STEP;
            imem_req    <= 1'b0;
            state_reg   <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            imem_addr   <= pc_reg;
            state_reg   <= REQ;
          end
        end
        DISCARD: begin
          // Stale response from a redirected request: drop it and refetch at pc.
          if (imem_ack) begin
            imem_addr <= pc_reg;
            state_reg <= REQ;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef DSP_FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_count <= 16'h0000;
      fetch_count <= 16'h0000;
    end else begin
      if (jump_flag && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'h0001;
      end
      if (instr_valid && instr_ready) begin
        fetch_count <= fetch_count + 16'h0001;
      end
    end
  end
`endif

endmodule
